// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Executes MULT, MULTU, DIV and DIVU with one radix-2 step per clock.
// Every operation takes exactly WIDTH steps, whatever the operands. It also
// takes direct MTHI/MTLO writes, and it drives HI/LO continuously for
// MFHI/MFLO.
//
// Ports
//   clk    in   core clock, rising edge
//   reset  in   synchronous active-high reset; aborts any running operation
//   start  in   request an operation (only honoured while idle)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   in   rs / rt operands (dividend / divisor for divides)
//   hi_we  in   MTHI write enable (only honoured while idle)
//   lo_we  in   MTLO write enable (only honoured while idle)
//   wdata  in   data for hi_we / lo_we
//   busy   out  operation in progress
//   done   out  one-cycle pulse: result committed to HI/LO
//   hi     out  HI (product upper half / remainder)
//   lo     out  LO (product lower half / quotient)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;    // partial product upper half / partial remainder
  logic [WIDTH-1:0]   r_q;      // multiplier being consumed / dividend-to-quotient
  logic [WIDTH-1:0]   r_m;      // multiplicand / divisor magnitude
  logic               r_div;    // 1: divide, 0: multiply
  logic               r_neg_q;  // negate product (mul) or quotient (div)
  logic               r_neg_r;  // negate remainder (dividend was negative)
  logic               r_dz;     // divide by zero: quotient stays all ones
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  // Operand conditioning at start: signed ops work on magnitudes.
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // One radix-2 step and the final sign-corrected result.
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_acc_n;
  logic [WIDTH-1:0]   w_q_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_last;

  always_comb begin
    w_signed = ~op[0];
    w_a_neg  = w_signed & a[WIDTH-1];
    w_b_neg  = w_signed & b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    w_a_mag  = w_a_neg ? -a : a;
    w_b_mag  = w_b_neg ? -b : b;
  end

  // NOTE: every always_comb output gets a default assignment first so no
  // path through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    w_acc_n  = r_acc;
    w_q_n    = r_q;
    w_res_hi = r_hi;
    w_res_lo = r_lo;

    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the {carry, acc, q} chain right by one.
    w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    // Restoring divide: shift in the next dividend bit and subtract if it fits.
    // The remainder is always below the divisor, so the low WIDTH bits of the
    // difference are exact whenever it is taken.
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_m});
    w_diff  = w_shift[WIDTH-1:0] - r_m;

    if (r_div) begin
      w_acc_n = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_q_n   = {r_q[WIDTH-2:0], w_ge};
    end else begin
      w_acc_n = w_sum[WIDTH:1];
      w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    w_prod     = {w_acc_n, w_q_n};
    w_prod_neg = -w_prod;

    if (r_div) begin
      // Divide by zero leaves quotient all ones and remainder |a|.
      // Re-applying the dividend sign to |a| restores a exactly.
      w_res_lo = (r_neg_q && !r_dz) ? -w_q_n : w_q_n;
      w_res_hi = r_neg_r ? -w_acc_n : w_acc_n;
    end else begin
      {w_res_hi, w_res_lo} = r_neg_q ? w_prod_neg : w_prod;
    end
  end

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // start takes priority; any MTHI/MTLO this cycle is dropped
            r_acc   <= '0;
            r_q     <= w_a_mag;
            r_m     <= w_b_mag;
            r_div   <= op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= op[1] & w_a_neg;
            r_dz    <= op[1] & (b == '0);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit with a WIDTH=32 and a WIDTH=8 instance.
// Expected {hi,lo} values are queued when an operation is started and popped
// when done pulses. Each operation also has its latency, busy length and
// done width checked, plus the behaviour of HI/LO during and after the run.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        hi_we8, lo_we8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Reference model for WIDTH=32 built on the simulator's own arithmetic.
  function automatic logic [63:0] model32(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy, p;
    int     qi, ri;
    logic [63:0] res;
    res = '0;
    case (o)
      2'b00: begin
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        p   = sx * sy;
        res = 64'(p);
      end
      2'b01: res = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          qi  = $signed(x) / $signed(y);
          ri  = $signed(x) % $signed(y);
          res = {32'(ri), 32'(qi)};
        end
      end
      default: begin
        if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
        else            res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Runs one WIDTH=32 operation. with_writes: pulse MTHI/MTLO alongside start.
  // disturb: pulse start/hi_we/lo_we mid-run. poke_done: pulse start/hi_we
  // while in DONE. The last two also watch for any stray done afterwards.
  task automatic run32(input string name, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp_v, input bit with_writes,
                       input bit disturb, input bit poke_done);
    logic [31:0] old_hi, old_lo;
    logic [63:0] e;
    int edges, bcnt, stray;
    sb32.push_back(exp_v);
    @(negedge clk);
    old_hi = hi;
    old_lo = lo;
    op = o; a = x; b = y; start = 1'b1;
    if (with_writes) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0123;
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    edges = 1;
    bcnt  = 0;
    n_tests++;
    if ({hi, lo} !== {old_hi, old_lo}) begin
      n_fail++;
      $display("FAIL %s hold_at_start: hi/lo=%h_%h required %h_%h", name, hi, lo, old_hi, old_lo);
    end
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) bcnt++;
      if (disturb && edges == 10) begin
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (edges == 16) begin
        n_tests++;
        if ({hi, lo} !== {old_hi, old_lo}) begin
          n_fail++;
          $display("FAIL %s hold_mid_run: hi/lo=%h_%h required %h_%h", name, hi, lo, old_hi, old_lo);
        end
      end
      @(negedge clk);
      edges++;
    end
    e = sb32.pop_front();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, required 33", name, edges);
    end else begin
      if ({hi, lo} !== e) begin
        n_fail++;
        $display("FAIL %s result: hi/lo=%h_%h required %h_%h", name, hi, lo, e[63:32], e[31:0]);
      end
      n_tests++;
      if (edges != 33 || bcnt != 32) begin
        n_fail++;
        $display("FAIL %s latency: done at %0d busy %0d cycles, required 33 and 32", name, edges, bcnt);
      end
    end
    if (poke_done) begin
      start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: done=%b busy=%b required 0 0", name, done, busy);
    end
    if (disturb || poke_done) begin
      stray = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) stray++;
      end
      n_tests++;
      if (stray != 0 || {hi, lo} !== e) begin
        n_fail++;
        $display("FAIL %s ignored_requests: stray busy/done cycles=%0d hi/lo=%h_%h required 0 and %h_%h",
                 name, stray, hi, lo, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic run8(input string name, input logic [1:0] o,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp_v);
    logic [15:0] e;
    int edges, bcnt;
    sb8.push_back(exp_v);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges  = 1;
    bcnt   = 0;
    while (done8 !== 1'b1 && edges < 100) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      edges++;
    end
    e = sb8.pop_front();
    n_tests++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, required 9", name, edges);
    end else begin
      if ({hi8, lo8} !== e) begin
        n_fail++;
        $display("FAIL %s result: hi/lo=%h_%h required %h_%h", name, hi8, lo8, e[15:8], e[7:0]);
      end
      n_tests++;
      if (edges != 9 || bcnt != 8) begin
        n_fail++;
        $display("FAIL %s latency: done at %0d busy %0d cycles, required 9 and 8", name, edges, bcnt);
      end
    end
    @(negedge clk);
    n_tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: done=%b busy=%b required 0 0", name, done8, busy8);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, hi, lo} !== 66'h0 || {busy8, done8, hi8, lo8} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state: w32 busy=%b done=%b hi=%h lo=%h w8 busy=%b done=%b hi=%h lo=%h required all 0",
               busy, done, hi, lo, busy8, done8, hi8, lo8);
    end
    reset = 1'b0;
  endtask

  task automatic test_multu_timing();
    run32("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 0);
  endtask

  task automatic test_signed();
    run32("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 0);
    run32("div_neg",  2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0);
  endtask

  task automatic test_div_special();
    run32("divu_by_zero", 2'b11, 32'h0000_0064, 32'h0, 64'h0000_0064_FFFF_FFFF, 0, 0, 0);
    run32("div_by_zero_neg", 2'b10, 32'hFFFF_FF9C, 32'h0, 64'hFFFF_FF9C_FFFF_FFFF, 0, 0, 0);
    run32("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, 0);
  endtask

  task automatic test_mtx_writes();
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_005A;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    n_tests++;
    if (hi !== 32'h5A || lo !== 32'h5A) begin
      n_fail++;
      $display("FAIL mt_both: hi=%h lo=%h required 0000005a 0000005a", hi, lo);
    end
    hi_we = 1'b1; wdata = 32'h0000_00F0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_000F;
    @(negedge clk);
    lo_we = 1'b0;
    n_tests++;
    if (hi !== 32'hF0 || lo !== 32'h0F) begin
      n_fail++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h required 000000f0 0000000f", hi, lo);
    end
    run32("divu_disturbed", 2'b11, 32'h0000_00CE, 32'h0000_0010, 64'h0000_000E_0000_000C, 0, 1, 1);
  endtask

  task automatic test_start_wins();
    run32("start_with_mt", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1, 0, 0);
  endtask

  task automatic test_reset_abort();
    int stray;
    @(negedge clk);
    op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    n_tests++;
    if (stray != 0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_no_done: stray cycles=%0d hi=%h lo=%h required 0 0 0", stray, hi, lo);
    end
    run32("multu_after_abort", 2'b01, 32'd7, 32'd9, 64'h0000_0000_0000_003F, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom();
      case ($urandom_range(0, 3))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 100));
        2:       y = -32'($urandom_range(1, 100));
        default: y = $urandom();
      endcase
      run32("random_op", o, x, y, model32(o, x, y), 0, 0, 0);
    end
  endtask

  task automatic test_width8();
    run8("w8_mult_min", 2'b00, 8'h80, 8'h80, 16'h4000);
    run8("w8_divu",     2'b11, 8'hFF, 8'h10, 16'h0F0F);
    run8("w8_div_neg",  2'b10, 8'h80, 8'hFF, 16'h0080);
    run8("w8_mult_mix", 2'b00, 8'hFD, 8'h05, 16'hFFF1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = '0;
    test_reset();
    test_multu_timing();
    test_signed();
    test_div_special();
    test_mtx_writes();
    test_start_wins();
    test_reset_abort();
    test_back_to_back();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
